serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//   Receive end of the one-bit-per-clock serial link. Collects bits arriving
//   index 0 first and rebuilds WIDTH-bit words. Words are held in a one-entry
//   output buffer with a valid/ready handshake for the downstream consumer.
//   Flags lost words (overrun) and truncated frames (resync).
// PARAMETERS
//   WIDTH       8  bits per word (>=2); word bit 0 is the first bit received
//   CONTINUOUS  1  1: back-to-back words without a new frame_start;
//                  0: return to IDLE after every word
// PORTS
//   CLK          in   1            clock, all logic on posedge
//   RST          in   1            asynchronous reset, active-high
//   bit_in       in   1            serial data bit
//   bit_valid    in   1            bit_in is meaningful this cycle
//   frame_start  in   1            with bit_valid: this bit is word bit 0
//   word_out     out  [0:WIDTH-1]  buffered word, bit 0 = first received
//   word_valid   out  1            word_out holds an unconsumed word
//   word_ready   in   1            consumer accepts word_out this cycle
//   bit_count    out  clog2(WIDTH) index of the next bit to be stored
//   busy         out  1            FSM in COLLECT
//   overrun      out  1            1-cycle pulse: completed word dropped
//   resync       out  1            1-cycle pulse: partial word discarded
// BEHAVIOUR
//   Reset (async, RST=1): state=IDLE; word_out=0; word_valid=0; bit_count=0;
//     busy=0; overrun=0; resync=0; shift register=0. The reset is asserted
//     asynchronously and released on a CLK edge. A partial word and any
//     buffered word are lost.
//   A bit is accepted on a posedge where bit_valid=1. Bits with bit_valid=0
//     are ignored; count and shift register hold.
//   FSM IDLE: ignore bits unless frame_start=1. On an accepted frame_start bit:
//     store it at index 0; bit_count=1; go to COLLECT.
//   FSM COLLECT: store the accepted bit at index bit_count, then increment.
//     frame_start=1 on an accepted bit in COLLECT with bit_count!=0: discard
//     the partial word; pulse resync; store this bit at index 0; bit_count=1.
//     On the bit at index WIDTH-1 (word complete):
//       - the complete word goes to the buffer on the same edge;
//       - bit_count returns to 0;
//       - next state is COLLECT if CONTINUOUS=1, IDLE otherwise.
//     With CONTINUOUS=1, a frame_start on the first bit after completion is
//       legal (count is 0) and does not pulse resync.
//   Output buffer transfer rule (on the completing edge):
//     - buffer empty, or word_valid & word_ready this cycle: load word_out;
//       word_valid=1. word_valid appears the cycle after the last bit's edge,
//       so latency is 0 extra cycles.
//     - otherwise: the new word is dropped, word_out is unchanged, and
//       overrun pulses for 1 cycle.
//   Handshake: word_valid & word_ready at a posedge consumes the word, and
//     word_valid falls unless the same edge loads a new word. word_out is
//     stable while word_valid=1. word_ready with word_valid=0 has no effect.
//   overrun and resync are registered and high for exactly one cycle per event.
//   bit_count never exceeds WIDTH-1; it wraps to 0 at word completion.
// TESTING
//   1. Reset, ready=1, CONTINUOUS=1. Send 1,0,1,0,1,0,1,1 (index 0 first,
//      frame_start on first) -> word_out=8'b10101011, word_valid 1 cycle.
//   2. Send 16 bits (0x55 then 0xF0), frame_start only on bit 0, ready=1
//      -> two words, 0x55 then 0xF0; no overrun.
//   3. ready=0, send two full words -> first word held; overrun pulses once
//      at the second completion; word_out stays the first word.
//   4. Send 5 bits, then frame_start with a new 8-bit word -> resync pulses
//      once; word_out = the new word only.
//   5. Insert bit_valid=0 gaps inside a word -> same word_out as with no gaps;
//      bit_count holds during the gaps.
//   6. Assert RST mid-word while word_valid=1 -> all outputs 0 immediately;
//      a full word after release is received correctly.

Source files
------------

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Receives a one-bit-per-clock serial stream and rebuilds WIDTH-bit words.
// Bit 0 of a word is the first bit received. Each finished word goes into a
// one-entry output buffer that a downstream consumer drains with a
// valid/ready handshake. Two one-cycle status pulses are produced:
//   overrun - a finished word was dropped because the buffer was still full
//   resync  - a frame_start arrived mid-word and the partial word was dropped
module serial_word_receiver #(
  parameter int WIDTH      = 8,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  output logic [0:WIDTH-1]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic                       busy,
  output logic                       overrun,
  output logic                       resync
);

  localparam int CW = $clog2(WIDTH);

  // Index of the final bit of a word; storing a bit here completes the word.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [0:WIDTH-1]    shift_q, shift_d;
  logic [CW-1:0]       count_q, count_d;
  logic [0:WIDTH-1]    word_q, word_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                resync_q, resync_d;

  // Word under construction with the current bit merged in at its index.
  logic [0:WIDTH-1]    assembled;
  // High when this edge stores the last bit of a word.
  logic                complete;
  // High when the consumer takes the buffered word on this edge.
  logic                consume;

  assign consume = valid_q & word_ready;

  // State register and all datapath flops; reset clears everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      resync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      resync_q  <= resync_d;
    end
  end

  // Bit collection FSM: decides where the incoming bit lands and whether a
  // word completes on this edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    resync_d  = 1'b0;
    complete  = 1'b0;
    assembled = shift_q;

    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          // Only a framed bit can start a word from idle.
          if (frame_start) begin
            shift_d    = '0;
            shift_d[0] = bit_in;
            count_d    = CW'(1);
            state_d    = COLLECT;
          end
        end

        COLLECT: begin
          if (frame_start && (count_q != '0)) begin
            // Frame restarted mid-word: throw away the partial word and
            // treat this bit as bit 0 of a fresh word.
            resync_d   = 1'b1;
            shift_d    = '0;
            shift_d[0] = bit_in;
            count_d    = CW'(1);
          end else begin
            // A frame_start at count 0 lands here too: it is simply bit 0.
            assembled[count_q] = bit_in;
            if (count_q == LAST_IDX) begin
              complete = 1'b1;
              shift_d  = '0;
              count_d  = '0;
              state_d  = CONTINUOUS ? COLLECT : IDLE;
            end else begin
              shift_d = assembled;
              count_d = count_q + CW'(1);
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output buffer: load a finished word if there is room (including room
  // freed by a consume on this same edge), otherwise drop it and flag it.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = assembled;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign bit_count  = count_q;
  assign busy       = (state_q == COLLECT);
  assign overrun    = overrun_q;
  assign resync     = resync_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=8, CONTINUOUS=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_serial_word_receiver;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RST;
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [0:WIDTH-1] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [2:0]       bit_count;
  logic             busy;
  logic             overrun;
  logic             resync;

  int n_total;
  int n_bad;

  serial_word_receiver #(
    .WIDTH      (WIDTH),
    .CONTINUOUS (1'b1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .bit_count   (bit_count),
    .busy        (busy),
    .overrun     (overrun),
    .resync      (resync)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bit_in      = b;
    frame_start = fs;
    bit_valid   = 1'b1;
    @(posedge CLK);
    #1;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle_cycle();
    bit_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Sends w[0] first; frame_start on bit 0 when fs0 is set.
  task automatic send_word(input logic [0:WIDTH-1] w, input logic fs0);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i], (i == 0) ? fs0 : 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " word_out"},   32'(word_out),   32'h0);
    check_val({tag, " word_valid"}, 32'(word_valid), 32'h0);
    check_val({tag, " bit_count"},  32'(bit_count),  32'h0);
    check_val({tag, " busy"},       32'(busy),       32'h0);
    check_val({tag, " overrun"},    32'(overrun),    32'h0);
    check_val({tag, " resync"},     32'(resync),     32'h0);
  endtask

  initial begin
    logic [0:WIDTH-1] w;
    n_total     = 0;
    n_bad       = 0;
    RST         = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    word_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;

    // Idle ignores bits without frame_start
    send_bit(1'b1, 1'b0);
    check_val("idle ignore count", 32'(bit_count), 32'h0);
    check_val("idle ignore busy",  32'(busy),      32'h0);

    // Test 1: 1,0,1,0,1,0,1,1 -> 8'b10101011
    w = 8'b10101011;
    send_bit(w[0], 1'b1);
    check_val("t1 count after bit0", 32'(bit_count), 32'h1);
    check_val("t1 busy",             32'(busy),      32'h1);
    for (int i = 1; i < WIDTH; i++) send_bit(w[i], 1'b0);
    check_val("t1 word_valid", 32'(word_valid), 32'h1);
    check_val("t1 word_out",   32'(word_out),   32'hAB);
    check_val("t1 count wrap", 32'(bit_count),  32'h0);
    check_val("t1 busy cont",  32'(busy),       32'h1);
    idle_cycle();
    check_val("t1 valid drop", 32'(word_valid), 32'h0);

    // Test 2: 0x55 then 0xF0 back to back
    send_word(8'h55, 1'b1);
    check_val("t2 w0 valid", 32'(word_valid), 32'h1);
    check_val("t2 w0 out",   32'(word_out),   32'h55);
    send_word(8'hF0, 1'b0);
    check_val("t2 w1 valid",   32'(word_valid), 32'h1);
    check_val("t2 w1 out",     32'(word_out),   32'hF0);
    check_val("t2 no overrun", 32'(overrun),    32'h0);
    idle_cycle();
    check_val("t2 valid drop", 32'(word_valid), 32'h0);

    // Test 3: ready low, two words -> overrun on the second
    word_ready = 1'b0;
    send_word(8'h3C, 1'b1);
    check_val("t3 w0 out",     32'(word_out), 32'h3C);
    check_val("t3 w0 overrun", 32'(overrun),  32'h0);
    send_word(8'hC3, 1'b0);
    check_val("t3 overrun",    32'(overrun),    32'h1);
    check_val("t3 held out",   32'(word_out),   32'h3C);
    check_val("t3 held valid", 32'(word_valid), 32'h1);
    idle_cycle();
    check_val("t3 overrun 1cyc", 32'(overrun),  32'h0);
    check_val("t3 still held",   32'(word_out), 32'h3C);
    word_ready = 1'b1;
    idle_cycle();
    check_val("t3 consumed", 32'(word_valid), 32'h0);

    // Test 4: 5 partial bits, then a framed new word -> one resync
    w = 8'hFF;
    send_bit(w[0], 1'b1);
    check_val("t4 no resync at count0", 32'(resync), 32'h0);
    for (int i = 1; i < 5; i++) send_bit(w[i], 1'b0);
    check_val("t4 partial count", 32'(bit_count), 32'h5);
    w = 8'h96;
    send_bit(w[0], 1'b1);
    check_val("t4 resync",       32'(resync),    32'h1);
    check_val("t4 restart count", 32'(bit_count), 32'h1);
    send_bit(w[1], 1'b0);
    check_val("t4 resync 1cyc", 32'(resync), 32'h0);
    for (int i = 2; i < WIDTH; i++) send_bit(w[i], 1'b0);
    check_val("t4 valid", 32'(word_valid), 32'h1);
    check_val("t4 out",   32'(word_out),   32'h96);
    idle_cycle();

    // Test 5: bit_valid gaps inside a word
    w = 8'h5A;
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i], (i == 0) ? 1'b1 : 1'b0);
      if (i == 2) begin
        bit_in = ~w[3];
        frame_start = 1'b1;
        idle_cycle();
        check_val("t5 gap count a", 32'(bit_count), 32'h3);
        idle_cycle();
        check_val("t5 gap count b", 32'(bit_count), 32'h3);
        frame_start = 1'b0;
      end
    end
    check_val("t5 valid", 32'(word_valid), 32'h1);
    check_val("t5 out",   32'(word_out),   32'h5A);
    idle_cycle();

    // Test 6: reset mid-word while a word is buffered
    word_ready = 1'b0;
    send_word(8'h0F, 1'b1);
    check_val("t6 buffered", 32'(word_valid), 32'h1);
    w = 8'hAA;
    for (int i = 0; i < 3; i++) send_bit(w[i], (i == 0) ? 1'b1 : 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("t6 async");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    word_ready = 1'b1;
    send_word(8'hE7, 1'b1);
    check_val("t6 post valid", 32'(word_valid), 32'h1);
    check_val("t6 post out",   32'(word_out),   32'hE7);
    idle_cycle();
    check_val("t6 post drop", 32'(word_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
